// File: rtl/snax_simbacore_csr_arbiter.sv
// Shares one CSR request/response channel between NumReq requesters; responses are routed in order via an ID FIFO.
// Optional build macro SNAX_SIMBACORE_CSR_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module snax_simbacore_csr_arbiter #(
  parameter int unsigned  NumReq         = 2,
  parameter int unsigned  MaxOutstanding = 4,
  localparam int unsigned IdW            = $clog2(NumReq),
  localparam int unsigned CntW           = $clog2(MaxOutstanding) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0][31:0] req_data_i,
  input  logic [NumReq-1:0][31:0] req_addr_i,
  input  logic [NumReq-1:0]       req_write_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic [NumReq-1:0][31:0] rsp_data_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output logic [31:0]             csr_req_data_o,
  output logic [31:0]             csr_req_addr_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [31:0]             csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic [CntW-1:0]         outstanding_o,
  output logic                    orphan_rsp_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  lock_q, lock_d;
  logic [IdW-1:0]  sel_id, cand, grant_id, head;
  logic            sel_found, grant_valid, req_hs;
  logic            fifo_full, fifo_empty, push, pop;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  assign fifo_full  = (count_q == CntW'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);

`ifndef SNAX_SIMBACORE_CSR_ARB_FIXED_PRIO_EN
  logic [IdW-1:0] rr_ptr_q;
`endif

  // First valid requester, scanning upward from the priority start point
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
`ifdef SNAX_SIMBACORE_CSR_ARB_FIXED_PRIO_EN
      cand = IdW'(i);
`else
      cand = IdW'((32'(rr_ptr_q) + i) % NumReq);
`endif
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Next state and grant; a grant stalled by the manager is locked until its handshake
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    grant_id    = sel_id;
    grant_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_id    = sel_id;
        grant_valid = sel_found & ~fifo_full & ~rst_i;
        if (grant_valid && !csr_req_ready_i) begin
          state_d = LOCKED;
          lock_d  = sel_id;
        end
      end
      LOCKED: begin
        grant_id    = lock_q;
        grant_valid = ~rst_i;
        if (csr_req_ready_i) state_d = IDLE;
      end
    endcase
  end

  assign req_hs          = grant_valid & csr_req_ready_i & ~fifo_full;
  assign csr_req_valid_o = grant_valid;
  assign csr_req_data_o  = req_data_i[grant_id];
  assign csr_req_addr_o  = req_addr_i[grant_id];
  assign csr_req_write_o = req_write_i[grant_id];

  assign head            = fifo_q[rd_ptr_q];
  assign csr_rsp_ready_o = ~rst_i & (fifo_empty | rsp_ready_i[head]);
  assign push            = req_hs;
  assign pop             = csr_rsp_valid_i & csr_rsp_ready_o & ~fifo_empty;
  assign outstanding_o   = count_q;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    for (int unsigned g = 0; g < NumReq; g++) begin
      req_ready_o[g] = req_hs && (grant_id == IdW'(g));
      rsp_valid_o[g] = csr_rsp_valid_i && !fifo_empty && (head == IdW'(g));
      rsp_data_o[g]  = csr_rsp_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // In-flight ID FIFO, priority pointer and orphan flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      orphan_rsp_o <= 1'b0;
`ifndef SNAX_SIMBACORE_CSR_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= grant_id;
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
`ifndef SNAX_SIMBACORE_CSR_ARB_FIXED_PRIO_EN
        rr_ptr_q <= (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + IdW'(1);
`endif
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
      if (csr_rsp_valid_i && fifo_empty) orphan_rsp_o <= 1'b1;
    end
  end

  // A locked requester must keep its request valid until accepted
  a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCKED) |-> req_valid_i[lock_q]);

endmodule
